// File: rtl/game_pkg.sv
// Shared types and constants for the game-over banner overlay.
package game_pkg;

  localparam int unsigned ROW_W  = 9;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned PIX_W  = 12;
  // Wide enough that TOP+H and LEFT+W cannot overflow in the window compare.
  localparam int unsigned CMP_W  = 11;

  localparam int unsigned LEFT      = 220;
  localparam int unsigned TOP       = 204;
  localparam int unsigned W         = 198;
  localparam int unsigned H         = 71;
  localparam logic [PIX_W-1:0] BG_COLOR = 12'hfff;

  localparam int unsigned BLINK_ON  = 30;
  localparam int unsigned BLINK_OFF = 15;
  localparam int unsigned LOCKOUT   = 60;

  localparam int unsigned FCNT_W = 6;  // holds 0..LOCKOUT
  localparam int unsigned PCNT_W = 5;  // holds 0..BLINK_ON-1

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

endpackage

// File: rtl/blink_timer.sv
// Frame-based lockout counter and banner blink phase for the OVER state.
// Ports: clk, rst_n; clear (hold counters at start values); frame_tick
// (advance once per frame); phase_on (banner visible phase);
// lockout_done (jump lockout elapsed).
module blink_timer
  import game_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic frame_tick,
  output logic phase_on,
  output logic lockout_done
);

  logic [FCNT_W-1:0] r_fcnt;
  logic [PCNT_W-1:0] r_pcnt;
  logic              r_phase_off;  // 0 = ON, so reset/clear land in the ON phase
  logic              w_pcnt_last;

  assign w_pcnt_last = r_phase_off ? (r_pcnt == PCNT_W'(BLINK_OFF - 1))
                                   : (r_pcnt == PCNT_W'(BLINK_ON - 1));

  // Counters only move on frame_tick so the banner never tears mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt      <= '0;
      r_pcnt      <= '0;
      r_phase_off <= 1'b0;
    end else if (clear) begin
      r_fcnt      <= '0;
      r_pcnt      <= '0;
      r_phase_off <= 1'b0;
    end else if (frame_tick) begin
      if (r_fcnt != FCNT_W'(LOCKOUT)) r_fcnt <= r_fcnt + FCNT_W'(1);
      if (w_pcnt_last) begin
        r_pcnt      <= '0;
        r_phase_off <= ~r_phase_off;
      end else begin
        r_pcnt      <= r_pcnt + PCNT_W'(1);
      end
    end
  end

  assign phase_on     = ~r_phase_off;
  assign lockout_done = (r_fcnt == FCNT_W'(LOCKOUT));

endmodule

// File: rtl/game_overlay_ctrl.sv
// Game-state sequencer (IDLE/RUN/OVER) and game-over banner compositor.
// Ports: clk, rst_n; frame_tick, collide, jump (game events); row, col
// (scan position); game_pix, banner_pix (colours, 1 cycle after row/col);
// d_out (composited colour, 2 cycles after row/col); run_en, score_clr,
// state (registered game-state outputs).
module game_overlay_ctrl
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             collide,
  input  logic             jump,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  logic [PIX_W-1:0] game_pix,
  input  logic [PIX_W-1:0] banner_pix,
  output logic [PIX_W-1:0] d_out,
  output logic             run_en,
  output logic             score_clr,
  output logic [1:0]       state
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_run_en;
  logic              r_score_clr;
  logic              r_win_d1;
  logic [PIX_W-1:0]  r_d_out;
  logic              w_in_win;
  logic              w_phase_on;
  logic              w_lockout_done;
  logic              w_timer_clr;
  logic              w_show;
  logic [CMP_W-1:0]  w_row_x;
  logic [CMP_W-1:0]  w_col_x;

  // Timer is held at its entry values outside OVER, so entering OVER
  // always starts with fcnt=0 and the banner in its visible phase.
  assign w_timer_clr = (r_state != ST_OVER);

  blink_timer u_blink_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (w_timer_clr),
    .frame_tick   (frame_tick),
    .phase_on     (w_phase_on),
    .lockout_done (w_lockout_done)
  );

  // Next-state logic; in RUN a collision takes priority over jump.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (jump)                   w_state_nxt = ST_RUN;
      ST_RUN:  if (collide)                w_state_nxt = ST_OVER;
      ST_OVER: if (jump && w_lockout_done) w_state_nxt = ST_RUN;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus registered run_en / score_clr derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_run_en    <= 1'b0;
      r_score_clr <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_run_en    <= (w_state_nxt == ST_RUN);
      r_score_clr <= (w_state_nxt == ST_RUN) && (r_state != ST_RUN);
    end
  end

  // Banner window; widened operands keep TOP+H / LEFT+W from wrapping.
  assign w_row_x  = CMP_W'(row);
  assign w_col_x  = CMP_W'(col);
  assign w_in_win = (w_row_x >= CMP_W'(TOP))  && (w_row_x < CMP_W'(TOP + H)) &&
                    (w_col_x >= CMP_W'(LEFT)) && (w_col_x < CMP_W'(LEFT + W));

  assign w_show = (r_state == ST_OVER) && w_phase_on && r_win_d1 &&
                  (banner_pix != BG_COLOR);

  // Two-stage pipeline: window delayed to meet the ROM/game pixels, then mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_d1 <= 1'b0;
      r_d_out  <= '0;
    end else begin
      r_win_d1 <= w_in_win;
      r_d_out  <= w_show ? banner_pix : game_pix;
    end
  end

  assign d_out     = r_d_out;
  assign run_en    = r_run_en;
  assign score_clr = r_score_clr;
  assign state     = r_state;

endmodule
